// File: rtl/reu_dma_seq.sv
// REU DMA transfer sequencer: bus-master engine that executes one committed
// stash / fetch / swap / verify command between C64 memory and expansion DRAM.
module reu_dma_seq #(
    parameter int EA_W    = 21,
    parameter bit PH_SYNC = 1'b1
) (
    input  logic            DotClk,
    input  logic            RESET,
    input  logic            PHI2,
    input  logic            BA,
    input  logic            Start,
    input  logic [1:0]      TType,
    input  logic [15:0]     CAIn,
    input  logic [EA_W-1:0] EAIn,
    input  logic [15:0]     LenIn,
    input  logic            FixCA,
    input  logic            FixEA,
    input  logic            Autoload,
    output logic            nDMA,
    output logic            BusAOE,
    output logic [15:0]     BusA,
    output logic            BusRnW,
    output logic            BusDOE,
    output logic [7:0]      BusDout,
    input  logic [7:0]      BusDin,
    output logic            MemReq,
    output logic            MemWE,
    output logic [EA_W-1:0] MemAddr,
    output logic [7:0]      MemWData,
    input  logic            MemAck,
    input  logic [7:0]      MemRData,
    output logic            Busy,
    output logic            Done,
    output logic            EndBlk,
    output logic            Fault,
    output logic [15:0]     CAOut,
    output logic [EA_W-1:0] EAOut,
    output logic [15:0]     LenOut
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAITBA, S_C64RD, S_MEMRD, S_C64WR, S_MEMWR, S_NEXT, S_DONE
    } state_t;

    localparam logic [1:0] TT_STASH  = 2'b00;
    localparam logic [1:0] TT_FETCH  = 2'b01;
    localparam logic [1:0] TT_SWAP   = 2'b10;
    localparam logic [1:0] TT_VERIFY = 2'b11;

    state_t          state_q, state_d;
    logic [15:0]     ca_q, ca_d, len_q, len_d, ca0_q, ca0_d, len0_q, len0_d;
    logic [EA_W-1:0] ea_q, ea_d, ea0_q, ea0_d;
    logic [7:0]      h_q, h_d, g_q, g_d;
    logic [1:0]      ttype_q, ttype_d;
    logic            fix_ca_q, fix_ca_d, fix_ea_q, fix_ea_d, autoload_q, autoload_d;
    logic            fault_q, fault_d, endblk_q, endblk_d, done_q, done_d;
    logic            busy_q, busy_d, ndma_q, ndma_d, wr_act_q, wr_act_d;
    logic            bus_aoe_q, bus_aoe_d, bus_rnw_q, bus_rnw_d, bus_doe_q, bus_doe_d;
    logic [15:0]     bus_a_q, bus_a_d;
    logic [7:0]      bus_dout_q, bus_dout_d;
    logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [EA_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]      mem_wdata_q, mem_wdata_d;
    logic [15:0]     ca_out_q, ca_out_d, len_out_q, len_out_d;
    logic [EA_W-1:0] ea_out_q, ea_out_d;

    // PHI2 edge detection, optionally behind one synchronising register
    logic phi_cur, phi_p_q, phi_rise, phi_fall;

    generate
        if (PH_SYNC) begin : g_phi_sync
            logic phi_s_q;
            always_ff @(posedge DotClk) begin
                if (RESET) phi_s_q <= 1'b0;
                else       phi_s_q <= PHI2;
            end
            assign phi_cur = phi_s_q;
        end else begin : g_phi_raw
            assign phi_cur = PHI2;
        end
    endgenerate

    always_ff @(posedge DotClk) begin
        if (RESET) phi_p_q <= 1'b0;
        else       phi_p_q <= phi_cur;
    end

    assign phi_rise = phi_cur & ~phi_p_q;
    assign phi_fall = ~phi_cur & phi_p_q;

    always_comb begin
        state_d     = state_q;
        ca_d        = ca_q;
        ea_d        = ea_q;
        len_d       = len_q;
        ca0_d       = ca0_q;
        ea0_d       = ea0_q;
        len0_d      = len0_q;
        h_d         = h_q;
        g_d         = g_q;
        ttype_d     = ttype_q;
        fix_ca_d    = fix_ca_q;
        fix_ea_d    = fix_ea_q;
        autoload_d  = autoload_q;
        fault_d     = fault_q;
        endblk_d    = endblk_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        ndma_d      = ndma_q;
        wr_act_d    = wr_act_q;
        bus_aoe_d   = bus_aoe_q;
        bus_rnw_d   = bus_rnw_q;
        bus_doe_d   = bus_doe_q;
        bus_a_d     = bus_a_q;
        bus_dout_d  = bus_dout_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ca_out_d    = ca_out_q;
        ea_out_d    = ea_out_q;
        len_out_d   = len_out_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    ca_d       = CAIn;
                    ea_d       = EAIn;
                    len_d      = LenIn;
                    ca0_d      = CAIn;
                    ea0_d      = EAIn;
                    len0_d     = LenIn;
                    h_d        = 8'h00;
                    ttype_d    = TType;
                    fix_ca_d   = FixCA;
                    fix_ea_d   = FixEA;
                    autoload_d = Autoload;
                    fault_d    = 1'b0;
                    endblk_d   = 1'b0;
                    ndma_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_WAITBA;
                end
            end
            S_WAITBA: begin
                if (phi_rise && BA) begin
                    if (ttype_q == TT_FETCH) begin
                        state_d = S_MEMRD;
                    end else begin
                        bus_aoe_d = 1'b1;
                        bus_rnw_d = 1'b1;
                        bus_a_d   = ca_q;
                        state_d   = S_C64RD;
                    end
                end
            end
            S_C64RD: begin
                if (phi_fall) begin
                    h_d       = BusDin;
                    bus_aoe_d = 1'b0;
                    state_d   = (ttype_q == TT_STASH) ? S_MEMWR : S_MEMRD;
                end
            end
            S_MEMRD: begin
                // Request is raised one cycle after entry and held steady until acknowledged
                if (mem_req_q && MemAck) begin
                    mem_req_d = 1'b0;
                    case (ttype_q)
                        TT_FETCH: begin
                            bus_dout_d = MemRData;
                            state_d    = S_C64WR;
                        end
                        TT_SWAP: begin
                            bus_dout_d = MemRData;
                            g_d        = h_q;
                            state_d    = S_C64WR;
                        end
                        default: begin
                            if (MemRData != h_q) fault_d = 1'b1;
                            state_d = S_NEXT;
                        end
                    endcase
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = ea_q;
                end
            end
            S_C64WR: begin
                if (!wr_act_q) begin
                    if (phi_rise && BA) begin
                        wr_act_d  = 1'b1;
                        bus_aoe_d = 1'b1;
                        bus_rnw_d = 1'b0;
                        bus_a_d   = ca_q;
                    end
                end else if (phi_fall) begin
                    // Data, address and R/W release together so D is never driven during a read
                    wr_act_d  = 1'b0;
                    bus_doe_d = 1'b0;
                    bus_aoe_d = 1'b0;
                    bus_rnw_d = 1'b1;
                    state_d   = (ttype_q == TT_SWAP) ? S_MEMWR : S_NEXT;
                end else begin
                    bus_doe_d = 1'b1;
                end
            end
            S_MEMWR: begin
                if (mem_req_q && MemAck) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_NEXT;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ea_q;
                    mem_wdata_d = (ttype_q == TT_SWAP) ? g_q : h_q;
                end
            end
            S_NEXT: begin
                if (!fix_ca_q) ca_d = ca_q + 16'd1;
                if (!fix_ea_q) ea_d = ea_q + {{(EA_W-1){1'b0}}, 1'b1};
                if (len_q == 16'd1 || fault_q) begin
                    state_d = S_DONE;
                end else begin
                    len_d   = len_q - 16'd1;
                    state_d = S_WAITBA;
                end
            end
            S_DONE: begin
                ndma_d    = 1'b1;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                endblk_d  = ~fault_q;
                ca_out_d  = autoload_q ? ca0_q  : ca_q;
                ea_out_d  = autoload_q ? ea0_q  : ea_q;
                len_out_d = autoload_q ? len0_q : len_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge DotClk) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            ca_q        <= '0;
            ea_q        <= '0;
            len_q       <= '0;
            ca0_q       <= '0;
            ea0_q       <= '0;
            len0_q      <= '0;
            h_q         <= '0;
            g_q         <= '0;
            ttype_q     <= '0;
            fix_ca_q    <= 1'b0;
            fix_ea_q    <= 1'b0;
            autoload_q  <= 1'b0;
            fault_q     <= 1'b0;
            endblk_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ndma_q      <= 1'b1;
            wr_act_q    <= 1'b0;
            bus_aoe_q   <= 1'b0;
            bus_rnw_q   <= 1'b1;
            bus_doe_q   <= 1'b0;
            bus_a_q     <= '0;
            bus_dout_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ca_out_q    <= '0;
            ea_out_q    <= '0;
            len_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            ca_q        <= ca_d;
            ea_q        <= ea_d;
            len_q       <= len_d;
            ca0_q       <= ca0_d;
            ea0_q       <= ea0_d;
            len0_q      <= len0_d;
            h_q         <= h_d;
            g_q         <= g_d;
            ttype_q     <= ttype_d;
            fix_ca_q    <= fix_ca_d;
            fix_ea_q    <= fix_ea_d;
            autoload_q  <= autoload_d;
            fault_q     <= fault_d;
            endblk_q    <= endblk_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ndma_q      <= ndma_d;
            wr_act_q    <= wr_act_d;
            bus_aoe_q   <= bus_aoe_d;
            bus_rnw_q   <= bus_rnw_d;
            bus_doe_q   <= bus_doe_d;
            bus_a_q     <= bus_a_d;
            bus_dout_q  <= bus_dout_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ca_out_q    <= ca_out_d;
            ea_out_q    <= ea_out_d;
            len_out_q   <= len_out_d;
        end
    end

    assign nDMA     = ndma_q;
    assign BusAOE   = bus_aoe_q;
    assign BusA     = bus_a_q;
    assign BusRnW   = bus_rnw_q;
    assign BusDOE   = bus_doe_q;
    assign BusDout  = bus_dout_q;
    assign MemReq   = mem_req_q;
    assign MemWE    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign EndBlk   = endblk_q;
    assign Fault    = fault_q;
    assign CAOut    = ca_out_q;
    assign EAOut    = ea_out_q;
    assign LenOut   = len_out_q;

endmodule

// File: tb/tb_reu_dma_seq.sv
// Bench for reu_dma_seq: C64 bus and DRAM models plus a byte-loop reference
// model of each command; directed cases followed by randomized commands.
module tb_reu_dma_seq;
    localparam int EA_W = 21;

    logic            DotClk = 1'b0;
    logic            RESET = 1'b1, PHI2 = 1'b0, BA = 1'b1, Start = 1'b0;
    logic [1:0]      TType = 2'b00;
    logic [15:0]     CAIn = '0, LenIn = '0;
    logic [EA_W-1:0] EAIn = '0;
    logic            FixCA = 1'b0, FixEA = 1'b0, Autoload = 1'b0;
    logic            nDMA, BusAOE, BusRnW, BusDOE, MemReq, MemWE;
    logic [15:0]     BusA, CAOut, LenOut;
    logic [7:0]      BusDout, BusDin, MemWData;
    logic [EA_W-1:0] MemAddr, EAOut;
    logic            MemAck = 1'b0;
    logic [7:0]      MemRData = 8'h00;
    logic            Busy, Done, EndBlk, Fault;

    reu_dma_seq #(.EA_W(EA_W), .PH_SYNC(1'b1)) dut (
        .DotClk(DotClk), .RESET(RESET), .PHI2(PHI2), .BA(BA), .Start(Start),
        .TType(TType), .CAIn(CAIn), .EAIn(EAIn), .LenIn(LenIn),
        .FixCA(FixCA), .FixEA(FixEA), .Autoload(Autoload),
        .nDMA(nDMA), .BusAOE(BusAOE), .BusA(BusA), .BusRnW(BusRnW),
        .BusDOE(BusDOE), .BusDout(BusDout), .BusDin(BusDin),
        .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemAck(MemAck), .MemRData(MemRData),
        .Busy(Busy), .Done(Done), .EndBlk(EndBlk), .Fault(Fault),
        .CAOut(CAOut), .EAOut(EAOut), .LenOut(LenOut)
    );

    always #5 DotClk = ~DotClk;

    int errors = 0;
    int checks = 0;

    logic [7:0] c64mem  [0:65535];
    logic [7:0] ref_c64 [0:65535];
    logic [7:0] dram    [int];
    logic [7:0] ref_dram[int];

    logic [63:0] rd_log[$], cw_log[$], dw_log[$];
    logic [63:0] exp_rd[$], exp_cw[$], exp_dw[$];
    logic [15:0]     exp_ca, exp_len;
    logic [EA_W-1:0] exp_ea;
    logic            exp_fault, exp_endblk;

    int mem_lat = 2;
    int mem_cnt = 0;
    int phi_cnt = 0;
    int done_cnt = 0;
    int viol_overlap = 0;
    int viol_ba = 0;

    function automatic logic [7:0] dflt(input int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ v[15:8] ^ v[20:13] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] rd_dram(input int a);
        return dram.exists(a) ? dram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] rd_ref(input int a);
        return ref_dram.exists(a) ? ref_dram[a] : dflt(a);
    endfunction

    assign BusDin = (BusAOE && BusRnW) ? c64mem[BusA] : 8'hFF;

    // PHI2 = DotClk/8
    always @(negedge DotClk) begin
        phi_cnt = phi_cnt + 1;
        PHI2 = phi_cnt[2];
    end

    // DRAM controller model: acknowledge after mem_lat cycles of request
    always @(negedge DotClk) begin
        if (MemAck) begin
            MemAck = 1'b0;
            mem_cnt = 0;
        end else if (MemReq) begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt >= mem_lat) begin
                MemAck = 1'b1;
                if (MemWE) begin
                    dram[int'(MemAddr)] = MemWData;
                    dw_log.push_back((64'(MemAddr) << 8) | 64'(MemWData));
                end else begin
                    MemRData = rd_dram(int'(MemAddr));
                end
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // C64 bus observer: records accesses, commits writes when D is released
    logic        aoe_prev = 1'b0, doe_prev = 1'b0;
    logic [15:0] w_a = '0;
    logic [7:0]  w_d = '0;
    always @(posedge DotClk) begin
        #2;
        if (BusDOE && (BusRnW || !BusAOE)) viol_overlap = viol_overlap + 1;
        if (BusAOE && !aoe_prev && !BA) viol_ba = viol_ba + 1;
        if (BusAOE && !aoe_prev && BusRnW) rd_log.push_back(64'(BusA));
        if (BusDOE) begin
            w_a = BusA;
            w_d = BusDout;
        end
        if (!BusDOE && doe_prev) begin
            c64mem[w_a] = w_d;
            cw_log.push_back((64'(w_a) << 8) | 64'(w_d));
        end
        if (Done) done_cnt = done_cnt + 1;
        aoe_prev = BusAOE;
        doe_prev = BusDOE;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the command byte by byte over private copies of both memories
    task automatic ref_model(input logic [1:0] tt, input logic [15:0] ca, input logic [EA_W-1:0] ea,
                             input logic [15:0] len, input logic fca, input logic fea, input logic al);
        logic [15:0]     c, l;
        logic [EA_W-1:0] e;
        logic            f;
        logic [7:0]      a, b;
        c = ca; e = ea; l = len; f = 1'b0;
        exp_rd.delete(); exp_cw.delete(); exp_dw.delete();
        while (1) begin
            a = ref_c64[c];
            b = rd_ref(int'(e));
            if (tt != 2'd1) exp_rd.push_back(64'(c));
            if (tt == 2'd0 || tt == 2'd2) begin
                exp_dw.push_back((64'(e) << 8) | 64'(a));
                ref_dram[int'(e)] = a;
            end
            if (tt == 2'd1 || tt == 2'd2) begin
                exp_cw.push_back((64'(c) << 8) | 64'(b));
                ref_c64[c] = b;
            end
            if (tt == 2'd3 && a != b) f = 1'b1;
            if (!fca) c = c + 16'd1;
            if (!fea) e = e + 1'b1;
            if (l == 16'd1 || f) break;
            l = l - 16'd1;
        end
        exp_ca     = al ? ca  : c;
        exp_ea     = al ? ea  : e;
        exp_len    = al ? len : l;
        exp_fault  = f;
        exp_endblk = !f;
    endtask

    task automatic check_log(input string tag, input logic [63:0] got[$], input logic [63:0] exp[$]);
        chk({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] tt, input logic [15:0] ca,
                           input logic [EA_W-1:0] ea, input logic [15:0] len,
                           input logic fca, input logic fea, input logic al);
        logic            got;
        logic [15:0]     o_ca, o_len;
        logic [EA_W-1:0] o_ea;
        logic            o_eb, o_ft, o_busy, o_ndma;
        int              v0, bound;
        ref_c64 = c64mem;
        ref_dram = dram;
        ref_model(tt, ca, ea, len, fca, fea, al);
        rd_log.delete(); cw_log.delete(); dw_log.delete();
        v0 = viol_overlap + viol_ba;
        @(negedge DotClk);
        TType = tt; CAIn = ca; EAIn = ea; LenIn = len;
        FixCA = fca; FixEA = fea; Autoload = al; Start = 1'b1;
        got = 1'b0;
        o_ca = '0; o_ea = '0; o_len = '0; o_eb = 1'b0; o_ft = 1'b0; o_busy = 1'b1; o_ndma = 1'b0;
        bound = 120 * int'(len) + 400;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge DotClk);
            // A second Start while busy must be ignored
            Start = (i == 6);
            if (i == 6) begin
                TType = ~tt; CAIn = ~ca; LenIn = 16'h0;
            end
            if (Done) begin
                got = 1'b1;
                o_ca = CAOut; o_ea = EAOut; o_len = LenOut;
                o_eb = EndBlk; o_ft = Fault; o_busy = Busy; o_ndma = nDMA;
            end
        end
        Start = 1'b0;
        chk({tag, "_done"}, 64'(got), 64'd1);
        chk({tag, "_caout"}, 64'(o_ca), 64'(exp_ca));
        chk({tag, "_eaout"}, 64'(o_ea), 64'(exp_ea));
        chk({tag, "_lenout"}, 64'(o_len), 64'(exp_len));
        chk({tag, "_endblk"}, 64'(o_eb), 64'(exp_endblk));
        chk({tag, "_fault"}, 64'(o_ft), 64'(exp_fault));
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_ndma"}, 64'(o_ndma), 64'd1);
        check_log({tag, "_c64rd"}, rd_log, exp_rd);
        check_log({tag, "_c64wr"}, cw_log, exp_cw);
        check_log({tag, "_dramwr"}, dw_log, exp_dw);
        chk({tag, "_busrules"}, 64'(viol_overlap + viol_ba - v0), 64'd0);
        @(negedge DotClk);
        chk({tag, "_done_pulse"}, 64'(Done), 64'd0);
        $display("%s: tt=%0d ca=%h ea=%h len=%h fix=%0d%0d al=%0d -> ca=%h ea=%h len=%h endblk=%0d fault=%0d",
                 tag, tt, ca, ea, len, fca, fea, al, o_ca, o_ea, o_len, o_eb, o_ft);
        repeat (3) @(negedge DotClk);
    endtask

    initial begin
        logic [1:0]      tt;
        logic [15:0]     ca, len;
        logic [EA_W-1:0] ea;
        logic            fca, fea, al, got;
        int              dc0, rd0;

        for (int i = 0; i < 65536; i++) c64mem[i] = 8'($urandom);

        repeat (4) @(negedge DotClk);
        chk("rst_ndma", 64'(nDMA), 64'd1);
        chk("rst_busaoe", 64'(BusAOE), 64'd0);
        chk("rst_busdoe", 64'(BusDOE), 64'd0);
        chk("rst_memreq", 64'(MemReq), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_endblk", 64'(EndBlk), 64'd0);
        chk("rst_fault", 64'(Fault), 64'd0);
        chk("rst_busa", 64'(BusA), 64'd0);
        chk("rst_memaddr", 64'(MemAddr), 64'd0);
        chk("rst_caout", 64'(CAOut), 64'd0);
        chk("rst_eaout", 64'(EAOut), 64'd0);
        chk("rst_lenout", 64'(LenOut), 64'd0);
        RESET = 1'b0;
        repeat (4) @(negedge DotClk);

        run_cmd("stash3", 2'd0, 16'hC000, 21'h010000, 16'h0003, 1'b0, 1'b0, 1'b0);

        dram[int'(21'h004000)] = 8'h5A;
        run_cmd("fetch1", 2'd1, 16'h0400, 21'h004000, 16'h0001, 1'b1, 1'b0, 1'b0);

        c64mem[16'h2000] = 8'h11; c64mem[16'h2001] = 8'h22;
        dram[int'(21'h000100)] = 8'hAA; dram[int'(21'h000101)] = 8'hBB;
        run_cmd("swap2", 2'd2, 16'h2000, 21'h000100, 16'h0002, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) dram[int'(21'h003000) + k] = c64mem[16'h3000 + 16'(k)];
        dram[int'(21'h003001)] = ~c64mem[16'h3001];
        run_cmd("verify4", 2'd3, 16'h3000, 21'h003000, 16'h0004, 1'b0, 1'b0, 1'b0);

        run_cmd("autoload", 2'd0, 16'h1234, 21'h1FFFFF, 16'h0002, 1'b0, 1'b0, 1'b1);

        // BA stall mid-transfer, then reset while a DRAM read is pending
        for (int k = 0; k < 8; k++) dram[int'(21'h005000) + k] = c64mem[16'h5000 + 16'(k)];
        mem_lat = 2;
        rd_log.delete();
        dc0 = done_cnt;
        @(negedge DotClk);
        TType = 2'd3; CAIn = 16'h5000; EAIn = 21'h005000; LenIn = 16'h0008;
        FixCA = 1'b0; FixEA = 1'b0; Autoload = 1'b0; Start = 1'b1;
        @(negedge DotClk);
        Start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge DotClk);
            if (rd_log.size() >= 2) got = 1'b1;
        end
        chk("stall_reached", 64'(got), 64'd1);
        BA = 1'b0;
        rd0 = rd_log.size();
        repeat (40) @(negedge DotClk);
        chk("stall_no_access", 64'(rd_log.size()), 64'(rd0));
        chk("stall_busy", 64'(Busy), 64'd1);
        chk("stall_ba_rule", 64'(viol_ba), 64'd0);
        BA = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge DotClk);
            if (MemReq && !MemWE) got = 1'b1;
        end
        chk("memrd_reached", 64'(got), 64'd1);
        RESET = 1'b1;
        @(negedge DotClk);
        RESET = 1'b0;
        chk("abort_ndma", 64'(nDMA), 64'd1);
        chk("abort_busaoe", 64'(BusAOE), 64'd0);
        chk("abort_memreq", 64'(MemReq), 64'd0);
        chk("abort_busy", 64'(Busy), 64'd0);
        repeat (30) @(negedge DotClk);
        chk("abort_no_done", 64'(done_cnt), 64'(dc0));
        $display("abort: reads_before_stall=%0d done_pulses=%0d busy=%0d", rd0, done_cnt - dc0, Busy);

        for (int n = 0; n < 10; n++) begin
            tt  = 2'($urandom_range(0, 3));
            ca  = 16'($urandom);
            ea  = EA_W'($urandom);
            len = 16'($urandom_range(1, 6));
            fca = ($urandom_range(0, 3) == 0);
            fea = ($urandom_range(0, 3) == 0);
            al  = ($urandom_range(0, 1) == 1);
            mem_lat = $urandom_range(1, 4);
            for (int k = 0; k < 8; k++) begin
                c64mem[ca + 16'(k)] = 8'($urandom);
                if (tt == 2'd3 && $urandom_range(0, 3) != 0)
                    dram[int'(EA_W'(ea + EA_W'(k)))] = c64mem[ca + 16'(k)];
                else
                    dram[int'(EA_W'(ea + EA_W'(k)))] = 8'($urandom);
            end
            if (tt == 2'd3 && $urandom_range(0, 1) == 1)
                dram[int'(EA_W'(ea + 1'b1))] = ~c64mem[ca + 16'd1];
            run_cmd($sformatf("rand%0d", n), tt, ca, ea, len, fca, fea, al);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reu_dma_seq.md
Name: reu_dma_seq

Overview:
- DMA transfer sequencer for the REU cartridge: the bus-master side that executes a committed command.
- The register file is the C64-facing responder; this block acts as initiator on the C64 expansion bus (nDMA, A, D, R/W) and on the DRAM controller request port.
- Moves bytes between C64 memory and expansion RAM: stash, fetch, swap, verify.
- Returns final address/length values and status strobes to the register file.

Parameters:
- EA_W, 21, expansion address width; EA wraps modulo 2^EA_W.
- PH_SYNC, 1, 1 registers PHI2 once before edge detect; 0 uses the raw PHI2 compare.

Ports:
- DotClk  in  1  system clock (PHI2 = DotClk/8, phase-locked).
- RESET  in  1  synchronous, active-high reset.
- PHI2  in  1  C64 phase-2 clock.
- BA  in  1  C64 bus available (high = bus usable).
- Start  in  1  one-DotClk pulse: execute command.
- TType  in  2  00 stash C64->REU, 01 fetch REU->C64, 10 swap, 11 verify.
- CAIn / EAIn / LenIn  in  16/EA_W/16  start values; LenIn 0 means 65536.
- FixCA, FixEA  in  1 each  hold the address instead of incrementing.
- Autoload  in  1  restore start values at end.
- nDMA  out  1  DMA request to C64, active low.
- BusAOE  out  1  drive A and R/W.
- BusA  out  16  C64 address.
- BusRnW  out  1  1 = read.
- BusDOE  out  1  drive D.
- BusDout  out  8  write data.
- BusDin  in  8  C64 data bus.
- MemReq  out  1  DRAM request; held until MemAck.
- MemWE  out  1  DRAM write.
- MemAddr  out  EA_W  DRAM address.
- MemWData  out  8  DRAM write data.
- MemAck  in  1  one-cycle completion.
- MemRData  in  8  read data, valid with MemAck.
- Busy  out  1  transfer in progress.
- Done  out  1  one-cycle pulse; CAOut/EAOut/LenOut valid and must be loaded.
- EndBlk, Fault  out  1 each  qualify Done.
- CAOut / EAOut / LenOut  out  16/EA_W/16  final register values.

Behaviour:
Reset:
- Outputs: nDMA=1; BusAOE=BusDOE=0; MemReq=0; Busy=Done=EndBlk=Fault=0; BusA/BusDout/MemAddr/MemWData/CAOut/EAOut/LenOut=0.
- State=IDLE. RESET mid-transfer aborts immediately, with no Done pulse.

PHI2 edges:
- Rise = PHI2 high & prior sample low; Fall = the reverse.
- One C64 access per PHI2 period.

States:
- IDLE: on Start, latch inputs into the working counters CA, EA, LEN and the hold register H; nDMA=0; Busy=1; go to WAITBA. Start while Busy is ignored.
- WAITBA: at Rise with BA=1, enter the first access state for TType: stash/swap/verify -> C64RD; fetch -> MEMRD.
- C64RD: from Rise to Fall, BusAOE=1, BusRnW=1, BusA=CA. At Fall, H<=BusDin; BusAOE drops the cycle after Fall. Next state: stash -> MEMWR; swap/verify -> MEMRD.
- MEMRD: MemReq=1, MemWE=0, MemAddr=EA. On MemAck: fetch -> C64WR with BusDout=MemRData; swap -> C64WR with BusDout=MemRData and G<=H; verify -> compare MemRData to H, mismatch sets Fault, then NEXT.
- C64WR: start only at a Rise with BA=1; otherwise wait. BusAOE=1, BusRnW=0, BusA=CA; BusDOE=1 from Rise+1 DotClk until Fall+1 DotClk. Next state: swap -> MEMWR (data G); otherwise NEXT.
- MEMWR: MemReq=1, MemWE=1, MemAddr=EA, MemWData=H (G for swap). On MemAck go to NEXT.
- NEXT (one cycle): if !FixCA, CA+1 mod 2^16; if !FixEA, EA+1 mod 2^EA_W.
  - If LEN==1 or Fault: DONE.
  - Else: LEN-1 (0 decrements to FFFF), then WAITBA.
- DONE (one cycle):
  - nDMA=1, Busy=0, Done=1.
  - EndBlk=1 iff LEN reached 1 without Fault.
  - Output values: Autoload ? start values : (CA, EA, LEN); LEN remains 1 at normal completion.
  - Return to IDLE. EndBlk and Fault hold until the next Start.

Rules:
- A C64 access never starts unless BA=1 at Rise; BA falling mid-transfer stalls at the next access boundary.
- MemReq, MemWE, MemAddr and MemWData are stable until MemAck.
- Verify mismatch terminates after that byte's address and length update is skipped: CAOut/EAOut point past the byte, and LenOut equals the LEN of the failing byte.
- Bus outputs never overlap BusDOE with BusRnW=1.

Test Plan:
- Stash, CAIn=C000, EAIn=010000, LenIn=0003, MemAck 2 cycles after each request, BA=1 -> three C64 reads at C000..C002 then DRAM writes to 010000..010002 with the read data. Done with EndBlk=1, CAOut=C003, EAOut=010003, LenOut=0001.
- Fetch, LenIn=0001, FixCA=1, MemRData=5A -> one C64 write at CAIn, data 5A, BusDOE only while BusRnW=0. CAOut=CAIn, LenOut=0001.
- Swap of 2 bytes, C64 data 11/22, DRAM data AA/BB -> C64 receives AA/BB, DRAM receives 11/22 at matching addresses.
- Verify of 4 bytes, mismatch at byte 2 -> Done after the second compare with Fault=1, EndBlk=0, CAOut=CAIn+2, LenOut=0003.
- Autoload stash, EAIn=1FFFFF, LenIn=0002 -> second DRAM address wraps to 000000; outputs equal the start values.
- BA=0 for 5 PHI2 periods mid-transfer, then RESET during MEMRD -> no bus drive while BA=0; after RESET, nDMA=1, BusAOE=0, MemReq=0, Busy=0, no Done pulse.
